// File: rtl/spiker_pkg.sv
// Shared types and default sizing for the spiker input-side reader.
package spiker_pkg;

  localparam int SPK_WIDTH      = 32;
  localparam int SPK_N_SPIKES   = 784;
  localparam int SPK_N_REG      = 25;
  localparam int SPK_DATA_WIDTH = SPK_N_REG * SPK_WIDTH;
  localparam int SPK_TS_WIDTH   = 16;
  localparam int SPK_IDX_W      = $clog2(SPK_N_REG);

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_LOAD,
    RD_PRESENT,
    RD_WAIT,
    RD_DONE
  } spiker_rd_state_e;

endpackage

// File: rtl/spiker_step_ctrl.sv
// Handshake and timestep bookkeeping for the reader: detects frame acceptance,
// counts completed steps and flags the step that reaches the programmed limit.
module spiker_step_ctrl
  import spiker_pkg::*;
#(
  parameter int TS_WIDTH = SPK_TS_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  spiker_rd_state_e      state,
  input  logic                  launch,
  input  logic                  abort,
  input  logic                  ready,
  input  logic                  step_done,
  input  logic [TS_WIDTH-1:0]   n_steps,
  output logic                  handshake,
  output logic                  step_evt,
  output logic                  last_step,
  output logic [TS_WIDTH-1:0]   step_cnt
);

  logic [TS_WIDTH-1:0] limit_q;
  logic [TS_WIDTH-1:0] cnt_q;
  logic [TS_WIDTH-1:0] cnt_inc;

  // Saturating increment; cannot actually saturate while limit fits in TS_WIDTH.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Abort wins over a coincident accept or step completion.
  assign handshake = (state == RD_PRESENT) && ready && !abort;
  assign step_evt  = (state == RD_WAIT) && step_done && !abort;
  assign last_step = step_evt && (cnt_inc == limit_q);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      limit_q <= '0;
      cnt_q   <= '0;
    end else if (launch) begin
      limit_q <= (n_steps == '0) ? TS_WIDTH'(1) : n_steps;
      cnt_q   <= '0;
    end else if (step_evt) begin
      cnt_q   <= cnt_inc;
    end
  end

  assign step_cnt = cnt_q;

endmodule

// File: rtl/spiker_reader.sv
// Assembles register-file spike words into the core input frame and replays it
// once per timestep over a valid/ready handshake for a programmed step count.
module spiker_reader
  import spiker_pkg::*;
#(
  parameter int WIDTH      = SPK_WIDTH,
  parameter int N_SPIKES   = SPK_N_SPIKES,
  parameter int N_REG      = SPK_N_REG,
  parameter int DATA_WIDTH = SPK_DATA_WIDTH,
  parameter int TS_WIDTH   = SPK_TS_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     test_mode_i,
  input  logic [N_REG*WIDTH-1:0]   spikes_words_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [TS_WIDTH-1:0]      n_steps_i,
  output logic [DATA_WIDTH-1:0]    data_in_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     step_done_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [TS_WIDTH-1:0]      step_cnt_o
);

  localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REG - 1);
  // Padding bits above the last real spike input are never presented.
  localparam logic [DATA_WIDTH-1:0] FRAME_MASK =
    {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - N_SPIKES);

  spiker_rd_state_e      state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] frame_q;
  logic                  done_q;

  logic launch;
  logic load_word;
  logic set_done;
  logic handshake;
  logic step_evt;
  logic last_step;

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  spiker_step_ctrl #(
    .TS_WIDTH (TS_WIDTH)
  ) u_step_ctrl (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .state     (state_q),
    .launch    (launch),
    .abort     (abort_i),
    .ready     (ready_i),
    .step_done (step_done_i),
    .n_steps   (n_steps_i),
    .handshake (handshake),
    .step_evt  (step_evt),
    .last_step (last_step),
    .step_cnt  (step_cnt_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    load_word = 1'b0;
    set_done  = 1'b0;
    if (state_q != RD_IDLE && abort_i) begin
      state_d = RD_IDLE;
    end else begin
      unique case (state_q)
        RD_IDLE: begin
          if (start_i) begin
            launch  = 1'b1;
            state_d = RD_LOAD;
          end
        end
        RD_LOAD: begin
          load_word = 1'b1;
          if (idx_q == LAST_IDX) state_d = RD_PRESENT;
        end
        RD_PRESENT: begin
          if (handshake) state_d = RD_WAIT;
        end
        RD_WAIT: begin
          if (step_evt) state_d = last_step ? RD_DONE : RD_PRESENT;
        end
        RD_DONE: begin
          set_done = 1'b1;
          state_d  = RD_IDLE;
        end
        default: state_d = RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (launch) begin
        idx_q  <= '0;
        done_q <= 1'b0;
      end else begin
        if (load_word) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        if (set_done)  done_q <= 1'b1;
      end
    end
  end

  // NOTE: the frame store is reset because the core may observe data_in_o
  // straight out of reset; a bare register array would power up undefined.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_q <= '0;
    end else if (load_word) begin
      for (int i = 0; i < N_REG; i++) begin
        if (idx_q == IDX_W'(i)) begin
          frame_q[i*WIDTH +: WIDTH] <= spikes_words_i[i*WIDTH +: WIDTH]
                                     & FRAME_MASK[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign data_in_o = frame_q;
  assign valid_o   = (state_q == RD_PRESENT);
  assign busy_o    = (state_q != RD_IDLE);
  assign done_o    = done_q;

endmodule

// File: tb/tb_spiker_reader.sv
// Directed bench for spiker_reader: table of run configurations plus
// hand-written abort, ignored-start and mid-load reset sequences.
module tb_spiker_reader;

  logic          clk_i;
  logic          rst_ni;
  logic          test_mode_i;
  logic [799:0]  spikes_words_i;
  logic          start_i;
  logic          abort_i;
  logic [15:0]   n_steps_i;
  logic [799:0]  data_in_o;
  logic          valid_o;
  logic          ready_i;
  logic          step_done_i;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   step_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [799:0] exp_frame;

  typedef struct {
    logic [15:0] n_steps;
    logic [31:0] base;
    int          hold;
    int          exp_steps;
  } vec_t;

  vec_t vecs[5];

  spiker_reader dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .test_mode_i    (test_mode_i),
    .spikes_words_i (spikes_words_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .n_steps_i      (n_steps_i),
    .data_in_o      (data_in_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .step_done_i    (step_done_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .step_cnt_o     (step_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [799:0] act, input logic [799:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp_v);
    end
  endtask

  task automatic set_frame(input logic [31:0] base);
    for (int i = 0; i < 25; i++) spikes_words_i[i*32 +: 32] = base + 32'(i);
    exp_frame = spikes_words_i;
    exp_frame[799:784] = '0;
  endtask

  // Pulse start, check start-of-run state, then wait for the first valid.
  task automatic start_and_wait();
    int cyc;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    check("start_busy", busy_o, 1);
    check("start_done_clr", done_o, 0);
    check("start_cnt_clr", step_cnt_o, 0);
    cyc = 1;
    while (!valid_o && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    check("valid_latency", cyc, 26);
  endtask

  task automatic handshake(input int hold);
    logic ok;
    ok = 1'b1;
    ready_i = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_i);
      ok = ok && valid_o && (data_in_o === exp_frame);
    end
    if (hold > 0) check("backpressure_hold", ok, 1);
    check("valid_before_hs", valid_o, 1);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check("valid_drop", valid_o, 0);
    check("frame", data_in_o, exp_frame);
  endtask

  task automatic step(input int gap);
    repeat (gap - 1) @(negedge clk_i);
    step_done_i = 1'b1;
    @(negedge clk_i);
    step_done_i = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy_o && cyc < 10) begin
      @(negedge clk_i);
      cyc++;
    end
    check("idle_timeout", busy_o, 0);
  endtask

  task automatic run_row(input vec_t v);
    set_frame(v.base);
    n_steps_i = v.n_steps;
    start_and_wait();
    check("pad_bits", data_in_o[799:784], 0);
    for (int s = 0; s < v.exp_steps; s++) begin
      handshake((s == 0) ? v.hold : 0);
      step(4);
      check("step_cnt", step_cnt_o, s + 1);
      if (s < v.exp_steps - 1) check("replay_valid", valid_o, 1);
    end
    wait_idle();
    check("done_set", done_o, 1);
    check("final_cnt", step_cnt_o, v.exp_steps);
    check("frame_held", data_in_o, exp_frame);
    repeat (3) @(negedge clk_i);
    check("done_sticky", done_o, 1);
    check("idle_valid", valid_o, 0);
  endtask

  initial begin
    vecs[0] = '{16'd1, 32'hA5A50000, 0,  1};
    vecs[1] = '{16'd3, 32'h5A5A0100, 0,  3};
    vecs[2] = '{16'd0, 32'h12340000, 0,  1};
    vecs[3] = '{16'd2, 32'hFFFF0000, 10, 2};
    vecs[4] = '{16'd4, 32'h0F0F0200, 0,  4};

    rst_ni = 1'b0;
    test_mode_i = 1'b0;
    spikes_words_i = '0;
    start_i = 1'b0;
    abort_i = 1'b0;
    n_steps_i = '0;
    ready_i = 1'b0;
    step_done_i = 1'b0;
    exp_frame = '0;
    repeat (3) @(negedge clk_i);
    check("rst_data", data_in_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_cnt", step_cnt_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int r = 0; r < 5; r++) run_row(vecs[r]);

    // Software edits during PRESENT, ignored start in WAIT, then abort in WAIT.
    set_frame(32'hC3C30000);
    n_steps_i = 16'd3;
    start_and_wait();
    spikes_words_i[31:0] = 32'h0;
    @(negedge clk_i);
    check("sw_edit_present", data_in_o, exp_frame);
    handshake(0);
    step(4);
    check("abort_pre_cnt", step_cnt_o, 1);
    handshake(0);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("start_ign_cnt", step_cnt_o, 1);
    check("start_ign_busy", busy_o, 1);
    check("start_ign_valid", valid_o, 0);
    @(negedge clk_i);
    check("start_ign_frame", data_in_o, exp_frame);
    abort_i = 1'b1;
    step_done_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    step_done_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_valid", valid_o, 0);
    check("abort_done", done_o, 0);
    check("abort_cnt", step_cnt_o, 1);
    check("abort_frame", data_in_o, exp_frame);
    repeat (2) @(negedge clk_i);
    check("abort_stays_idle", {busy_o, valid_o}, 0);

    run_row(vecs[1]);

    // Asynchronous reset while loading word 10.
    set_frame(32'h3C3C0000);
    n_steps_i = 16'd2;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("midload_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    check("mrst_data", data_in_o, 0);
    check("mrst_valid", valid_o, 0);
    check("mrst_busy", busy_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_cnt", step_cnt_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (30) @(negedge clk_i);
    check("mrst_idle", {busy_o, valid_o}, 0);

    run_row(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
